// File: rtl/projectile_engine_pkg.sv
// Shared types and constants for the projectile engine: coordinate space,
// game-state encoding and the unsigned distance helper used for collisions.
package projectile_engine_pkg;

  localparam int COORD_W = 9;
  localparam logic [COORD_W-1:0] MAX_X = COORD_W'(319);
  localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(239);

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    COOLDOWN = 2'd1,
    OVER     = 2'd2
  } state_e;

  // Widened by one bit so the sign of a-b is available before folding.
  function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
    logic [COORD_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[COORD_W] ? (~d + 1'b1) : d;
  endfunction

endpackage

// File: rtl/projectile_engine_channel.sv
// One projectile: position registers, linear/homing step with wrap/clamp,
// respawn override and box collision against the character.
module projectile_engine_channel
  import projectile_engine_pkg::*;
#(
  parameter int HIT_R = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               respawn_i,
  input  logic               move_i,
  input  logic               mode_i,
  input  logic [COORD_W-1:0] spawn_x_i,
  input  logic [COORD_W-1:0] spawn_y_i,
  input  logic [COORD_W-1:0] char_x_i,
  input  logic [COORD_W-1:0] char_y_i,
  output logic [COORD_W-1:0] pos_x_o,
  output logic [COORD_W-1:0] pos_y_o,
  output logic               collide_o
);

  localparam logic [COORD_W:0] HIT_R_C = HIT_R[COORD_W:0];

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] cur_x, cur_y, step_x, step_y;
  logic [COORD_W:0]   dx, dy;
  // Set by reset: the position follows the live spawn inputs until the first edge.
  logic               fresh_q;

  always_comb begin
    cur_x  = fresh_q ? spawn_x_i : x_q;
    cur_y  = fresh_q ? spawn_y_i : y_q;
    step_x = cur_x;
    step_y = cur_y;
    if (mode_i) begin
      if (char_x_i > cur_x)      step_x = cur_x + 1'b1;
      else if (char_x_i < cur_x) step_x = cur_x - 1'b1;
      if (cur_y > MAX_Y)                          step_y = MAX_Y;
      else if (char_y_i > cur_y && cur_y < MAX_Y) step_y = cur_y + 1'b1;
      else if (char_y_i < cur_y)                  step_y = cur_y - 1'b1;
    end else begin
      step_x = (cur_x == MAX_X) ? '0 : cur_x + 1'b1;
    end

    x_d = cur_x;
    y_d = cur_y;
    if (respawn_i) begin
      x_d = spawn_x_i;
      y_d = spawn_y_i;
    end else if (move_i) begin
      x_d = step_x;
      y_d = step_y;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_q     <= '0;
      y_q     <= '0;
      fresh_q <= 1'b1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      fresh_q <= 1'b0;
    end
  end

  assign dx        = abs_diff(cur_x, char_x_i);
  assign dy        = abs_diff(cur_y, char_y_i);
  assign collide_o = (dx <= HIT_R_C) && (dy <= HIT_R_C);
  assign pos_x_o   = cur_x;
  assign pos_y_o   = cur_y;

endmodule

// File: rtl/projectile_engine.sv
// Enemy projectile engine: base tick divider, per-channel speed gating,
// hit arbitration, health counter and PLAY/COOLDOWN/OVER game-state FSM.
module projectile_engine
  import projectile_engine_pkg::*;
#(
  parameter int NUM_PROJ     = 3,
  parameter int TICK_DIV     = 833333,
  parameter int HIT_R        = 4,
  parameter int HEALTH_W     = 7,
  parameter int INVULN_TICKS = 30,
  localparam int ID_W        = (NUM_PROJ > 1) ? $clog2(NUM_PROJ) : 1
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic                        restart,
  input  logic [COORD_W-1:0]          char_x,
  input  logic [COORD_W-1:0]          char_y,
  input  logic [NUM_PROJ-1:0]         mode,
  input  logic [2*NUM_PROJ-1:0]       speed_sh,
  input  logic [NUM_PROJ*COORD_W-1:0] spawn_x,
  input  logic [NUM_PROJ*COORD_W-1:0] spawn_y,
  input  logic                        goal_reached,
  output logic [NUM_PROJ*COORD_W-1:0] proj_x,
  output logic [NUM_PROJ*COORD_W-1:0] proj_y,
  output logic                        hit,
  output logic [ID_W-1:0]             hit_id,
  output logic [HEALTH_W-1:0]         health,
  output logic                        invuln,
  output logic                        game_over
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int COOL_W = $clog2(INVULN_TICKS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(INVULN_TICKS - 1);

  logic [DIV_W-1:0]    div_q, div_d;
  logic [7:0]          tick_cnt_q, tick_cnt_d;
  logic                tick;
  state_e              state_q, state_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic                hit_q, hit_d;
  logic [ID_W-1:0]     hit_id_q, hit_id_d, coll_id;
  logic [COOL_W-1:0]   cool_q, cool_d;
  logic [NUM_PROJ-1:0] collide, move;
  logic                accept_hit, respawn;

  // Base tick: the divider and the free tick count both stall while paused.
  assign tick       = enable && (div_q == DIV_LAST);
  assign div_d      = !enable ? div_q : (tick ? '0 : div_q + 1'b1);
  assign tick_cnt_d = tick ? tick_cnt_q + 8'd1 : tick_cnt_q;

  assign accept_hit = (state_q == PLAY) && (|collide) && !restart;
  assign respawn    = restart || accept_hit;

  for (genvar gi = 0; gi < NUM_PROJ; gi++) begin : g_ch
    logic [7:0] mask;
    assign mask     = (8'd1 << speed_sh[2*gi +: 2]) - 8'd1;
    assign move[gi] = tick && (state_q != OVER) && ((tick_cnt_q & mask) == 8'd0);

    projectile_engine_channel #(.HIT_R(HIT_R)) u_ch (
      .clock     (clock),
      .resetn    (resetn),
      .respawn_i (respawn),
      .move_i    (move[gi]),
      .mode_i    (mode[gi]),
      .spawn_x_i (spawn_x[gi*COORD_W +: COORD_W]),
      .spawn_y_i (spawn_y[gi*COORD_W +: COORD_W]),
      .char_x_i  (char_x),
      .char_y_i  (char_y),
      .pos_x_o   (proj_x[gi*COORD_W +: COORD_W]),
      .pos_y_o   (proj_y[gi*COORD_W +: COORD_W]),
      .collide_o (collide[gi])
    );
  end

  always_comb begin
    coll_id = '0;
    for (int i = NUM_PROJ - 1; i >= 0; i--)
      if (collide[i]) coll_id = ID_W'(i);
  end

  always_comb begin
    state_d  = state_q;
    health_d = health_q;
    hit_d    = 1'b0;
    hit_id_d = hit_id_q;
    cool_d   = cool_q;
    if (restart) begin
      state_d  = PLAY;
      health_d = '1;
      cool_d   = '0;
    end else begin
      case (state_q)
        PLAY: begin
          if (|collide) begin
            hit_d    = 1'b1;
            hit_id_d = coll_id;
            cool_d   = '0;
            // A goal in the same cycle cancels the damage.
            if (!goal_reached && health_q != '0) health_d = health_q - 1'b1;
            state_d  = (health_d == '0) ? OVER : COOLDOWN;
          end else if (goal_reached && health_q != '1) begin
            health_d = health_q + 1'b1;
          end
        end
        COOLDOWN: begin
          if (goal_reached && health_q != '1) health_d = health_q + 1'b1;
          if (tick) begin
            if (cool_q == COOL_LAST) begin
              state_d = PLAY;
              cool_d  = '0;
            end else begin
              cool_d  = cool_q + 1'b1;
            end
          end
        end
        OVER:    state_d = OVER;
        default: state_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_q      <= '0;
      tick_cnt_q <= '0;
      state_q    <= PLAY;
      health_q   <= '1;
      hit_q      <= 1'b0;
      hit_id_q   <= '0;
      cool_q     <= '0;
    end else begin
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      health_q   <= health_d;
      hit_q      <= hit_d;
      hit_id_q   <= hit_id_d;
      cool_q     <= cool_d;
    end
  end

  assign hit       = hit_q;
  assign hit_id    = hit_id_q;
  assign health    = health_q;
  assign invuln    = (state_q == COOLDOWN);
  assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_projectile_engine.sv
// Randomised and directed bench for projectile_engine, checked every cycle
// against a game-rule reference model kept in plain integers.
module tb_projectile_engine;

  localparam int NP = 3, CW = 9, TD = 2, HR = 4, INV = 30, HMAX = 127;
  localparam int MAXX = 319, MAXY = 239;
  localparam int S_PLAY = 0, S_COOL = 1, S_OVER = 2;

  logic clock = 1'b0;
  logic resetn, enable, restart, goal_reached;
  logic [CW-1:0]    char_x, char_y;
  logic [NP-1:0]    mode;
  logic [2*NP-1:0]  speed_sh;
  logic [NP*CW-1:0] spawn_x, spawn_y, proj_x, proj_y;
  logic             hit, invuln, game_over;
  logic [1:0]       hit_id;
  logic [6:0]       health;

  int n_checks = 0, n_err = 0;
  int mx[NP], my[NP];
  int mh, mst, mhit, mid, men, mticks, mcool;

  always #5 clock = ~clock;

  projectile_engine #(
    .NUM_PROJ(NP), .TICK_DIV(TD), .HIT_R(HR), .HEALTH_W(7), .INVULN_TICKS(INV)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .restart(restart),
    .char_x(char_x), .char_y(char_y), .mode(mode), .speed_sh(speed_sh),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .goal_reached(goal_reached),
    .proj_x(proj_x), .proj_y(proj_y), .hit(hit), .hit_id(hit_id),
    .health(health), .invuln(invuln), .game_over(game_over)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sx(input int i);
    return int'(spawn_x[i*CW +: CW]);
  endfunction

  function automatic int sy(input int i);
    return int'(spawn_y[i*CW +: CW]);
  endfunction

  task automatic set_spawn(input int i, input int x, input int y);
    spawn_x[i*CW +: CW] = x[CW-1:0];
    spawn_y[i*CW +: CW] = y[CW-1:0];
  endtask

  function automatic int m_cid();
    int c = -1;
    for (int i = NP - 1; i >= 0; i--)
      if (absi(mx[i] - int'(char_x)) <= HR && absi(my[i] - int'(char_y)) <= HR) c = i;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      mx[i] = sx(i);
      my[i] = sy(i);
    end
    mh = HMAX; mst = S_PLAY; mhit = 0; mid = 0; men = 0; mticks = 0; mcool = 0;
  endtask

  task automatic model_respawn();
    for (int i = 0; i < NP; i++) begin
      mx[i] = sx(i);
      my[i] = sy(i);
    end
  endtask

  // One clock of game rules, evaluated from the inputs present before the edge.
  task automatic model_step();
    bit tick;
    int cid, ny, sh;
    tick = enable && ((men + 1) % TD == 0);
    cid  = m_cid();
    mhit = 0;
    if (restart) begin
      model_respawn();
      mh = HMAX; mst = S_PLAY; mcool = 0;
    end else if (mst == S_PLAY && cid >= 0) begin
      mhit = 1;
      mid  = cid;
      if (!goal_reached && mh > 0) mh = mh - 1;
      model_respawn();
      mst   = (mh == 0) ? S_OVER : S_COOL;
      mcool = 0;
    end else if (mst != S_OVER) begin
      if (goal_reached && mh < HMAX) mh = mh + 1;
      if (tick) begin
        for (int i = 0; i < NP; i++) begin
          sh = int'(speed_sh[2*i +: 2]);
          if (mticks % (1 << sh) == 0) begin
            if (mode[i]) begin
              if (int'(char_x) > mx[i]) mx[i]++;
              else if (int'(char_x) < mx[i]) mx[i]--;
              ny = my[i];
              if (int'(char_y) > ny) ny++;
              else if (int'(char_y) < ny) ny--;
              my[i] = (ny > MAXY) ? MAXY : ny;
            end else begin
              mx[i] = (mx[i] == MAXX) ? 0 : (mx[i] + 1) % 512;
            end
          end
        end
      end
      if (mst == S_COOL && tick) begin
        mcool++;
        if (mcool == INV) mst = S_PLAY;
      end
    end
    if (enable) men++;
    if (tick) mticks++;
  endtask

  task automatic compare_all();
    for (int i = 0; i < NP; i++) begin
      check($sformatf("proj_x%0d", i), proj_x[i*CW +: CW], mx[i]);
      check($sformatf("proj_y%0d", i), proj_y[i*CW +: CW], my[i]);
    end
    check("hit", hit, mhit);
    if (mhit != 0) check("hit_id", hit_id, mid);
    check("health", health, mh);
    check("invuln", invuln, mst == S_COOL);
    check("game_over", game_over, mst == S_OVER);
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    compare_all();
    restart      = 1'b0;
    goal_reached = 1'b0;
  endtask

  initial begin
    int hq[$];
    int pre, t0, cnt, h0, rec_x, rec_y, k;

    resetn = 1'b0; enable = 1'b0; restart = 1'b0; goal_reached = 1'b0;
    char_x = 9'd10; char_y = 9'd230;
    mode = 3'b010; speed_sh = 6'b000000;
    set_spawn(0, 318, 10); set_spawn(1, 100, 50); set_spawn(2, 200, 200);
    model_reset();
    #12;
    check("rst_health", health, 127);
    check("rst_hit", hit, 0);
    check("rst_invuln", invuln, 0);
    check("rst_game_over", game_over, 0);
    check("rst_proj_x0", proj_x[0 +: CW], 318);
    check("rst_proj_y2", proj_y[2*CW +: CW], 200);
    $display("txn reset: health=%0d proj_x0=%0d", health, proj_x[0 +: CW]);

    // Linear wrap on channel 0, one base tick every TD cycles.
    resetn = 1'b1; enable = 1'b1;
    step(); step();
    check("wrap_319", proj_x[0 +: CW], 319);
    step(); step();
    check("wrap_0", proj_x[0 +: CW], 0);
    $display("txn linear wrap: proj_x0=%0d", proj_x[0 +: CW]);

    // Character over channel 2 -> accepted hit, then homing test during cooldown.
    char_x = mx[2][CW-1:0]; char_y = my[2][CW-1:0];
    step();
    check("hit_pulse", hit, 1);
    check("hit_id2", hit_id, 2);
    check("hit_health", health, 126);
    check("hit_invuln", invuln, 1);
    check("hit_respawn_x2", proj_x[2*CW +: CW], 200);
    $display("txn hit: id=%0d health=%0d", hit_id, health);
    char_x = 9'd103; char_y = 9'd50; mode = 3'b010;
    cnt = 0; k = 0;
    while (invuln && k < 200) begin
      pre = invuln; t0 = mticks;
      step();
      if (mticks != t0) begin
        if (pre != 0) cnt++;
        if (hq.size() < 4) hq.push_back(int'(proj_x[CW +: CW]));
      end
      k++;
    end
    check("home_t1", hq.size() > 0 ? hq[0] : -1, 101);
    check("home_t2", hq.size() > 1 ? hq[1] : -1, 102);
    check("home_t3", hq.size() > 2 ? hq[2] : -1, 103);
    check("home_hold", hq.size() > 3 ? hq[3] : -1, 103);
    check("invuln_ticks", cnt, INV);
    $display("txn cooldown: ticks=%0d homing x=%0d", cnt, proj_x[CW +: CW]);

    // Restart with new spawns, two channels colliding at once.
    enable = 1'b0;
    set_spawn(0, 150, 100); set_spawn(1, 152, 100); set_spawn(2, 20, 20);
    char_x = 9'd151; char_y = 9'd100;
    restart = 1'b1;
    step();
    check("restart_health", health, 127);
    step();
    check("dual_hit_id", hit_id, 0);
    check("dual_health", health, 126);
    $display("txn simultaneous: id=%0d health=%0d", hit_id, health);

    // Hit and goal in the same cycle leave health unchanged.
    mode = 3'b011; enable = 1'b1; k = 0;
    while (k < 200) begin
      if (mst == S_PLAY && m_cid() >= 0) begin
        h0 = mh;
        goal_reached = 1'b1;
        step();
        check("goal_hit_pulse", hit, 1);
        check("goal_hit_health", health, h0);
        break;
      end
      step();
      k++;
    end
    check("goal_hit_reached", k < 200, 1);
    $display("txn hit+goal: health=%0d", health);

    // Repeated hits until health runs out.
    k = 0;
    while (!game_over && k < 12000) begin
      step();
      k++;
    end
    check("over_flag", game_over, 1);
    check("over_health", health, 0);
    rec_x = mx[0]; rec_y = my[0];
    char_x = 9'd10; char_y = 9'd10; goal_reached = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("over_frozen_x", proj_x[0 +: CW], rec_x);
    check("over_frozen_y", proj_y[0 +: CW], rec_y);
    restart = 1'b1;
    step();
    check("over_restart_health", health, 127);
    check("over_restart_flag", game_over, 0);
    $display("txn game over: cycles=%0d then restart health=%0d", k, health);

    // Randomised play.
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        mode = NP'($urandom);
        speed_sh = (2*NP)'($urandom);
        for (int i = 0; i < NP; i++)
          set_spawn(i, $urandom_range(0, MAXX), $urandom_range(0, MAXY));
      end
      enable       = ($urandom % 16) != 0;
      restart      = ($urandom % 400) == 0;
      goal_reached = ($urandom % 40) == 0;
      if ($urandom % 20 == 0) begin
        k = $urandom_range(0, NP - 1);
        char_x = CW'(mx[k] + $urandom_range(0, 8) - 4);
        char_y = CW'(my[k] + $urandom_range(0, 8) - 4);
      end else begin
        char_x = char_x + CW'($urandom_range(0, 2)) - 9'd1;
        char_y = char_y + CW'($urandom_range(0, 2)) - 9'd1;
      end
      step();
    end
    $display("txn random: health=%0d checks=%0d", health, n_checks);

    // Async reset in the middle of a paused cooldown.
    enable = 1'b1; mode = 3'b000; speed_sh = 6'b0;
    set_spawn(0, 40, 40); set_spawn(1, 300, 10); set_spawn(2, 10, 200);
    char_x = 9'd40; char_y = 9'd40;
    restart = 1'b1;
    step();
    step();
    check("pre_rst_invuln", invuln, 1);
    enable = 1'b0;
    step(); step();
    #2;
    resetn = 1'b0;
    #1;
    check("arst_health", health, 127);
    check("arst_hit", hit, 0);
    check("arst_invuln", invuln, 0);
    check("arst_game_over", game_over, 0);
    check("arst_hit_id", hit_id, 0);
    check("arst_proj_x0", proj_x[0 +: CW], 40);
    check("arst_proj_x1", proj_x[CW +: CW], 300);
    check("arst_proj_y2", proj_y[2*CW +: CW], 200);
    $display("txn async reset: health=%0d invuln=%0d", health, invuln);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
